// File: rtl/panel_pkg.sv
// Shared phase codes and fixed bus constants for the panel bus scheduler.
package panel_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_CLEAR  = 3'd1,
        PH_CATH   = 3'd2,
        PH_ANODE  = 3'd3,
        PH_KBWR   = 3'd4,
        PH_KBRD   = 3'd5,
        PH_MSADDR = 3'd6,
        PH_MSDATA = 3'd7
    } phase_e;

    localparam logic [7:0] KBRD_BUS = 8'h09;

endpackage

// File: rtl/panel_phase_timer.sv
// Counts Tick pulses inside one bus phase; flags the phase's last Tick and
// the strobe window (from after the first Tick up to the next-to-last Tick).
module panel_phase_timer #(
    parameter int unsigned PHASE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic active,
    output logic phase_end_c,
    output logic strobe_win_c
);
    localparam int unsigned CW = $clog2(PHASE_TICKS);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d       = cnt_q;
        phase_end_c = 1'b0;
        if (!active) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CW'(PHASE_TICKS - 1)) begin
                cnt_d       = '0;
                phase_end_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // Window looks at the post-edge count so the registered strobe lines up with it
        strobe_win_c = (cnt_d != '0) && (cnt_d <= CW'(PHASE_TICKS - 2));
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/panel_bus_scheduler.sv
// Frame-driven scheduler multiplexing display, keyboard and (with
// PANEL_MS6205_EN defined) MS6205 writes onto one shared 8-bit panel bus.
module panel_bus_scheduler
    import panel_pkg::*;
#(
    parameter int unsigned ANODE_COUNT = 8,
    parameter int unsigned DIGIT_WIDTH = 3,
    parameter int unsigned KB_ROWS     = 7,
    parameter int unsigned PHASE_TICKS = 4,
    parameter int unsigned FRAME_TICKS = 4000
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             Tick,
    input  logic [ANODE_COUNT*DIGIT_WIDTH-1:0] DigitsHigh,
    input  logic [ANODE_COUNT*DIGIT_WIDTH-1:0] DigitsLow,
    input  logic [KB_ROWS-1:0]               KbRow,
    output logic [7:0]                       BusData,
    output logic [2:0]                       BusPhase,
    output logic                             WriteCathode,
    output logic                             WriteAnode,
    output logic                             KbWrite,
    output logic                             KbRead,
    output logic                             DispClear,
    output logic                             KbClear,
    output logic [3:0]                       AnodeIdx,
    output logic [ANODE_COUNT*KB_ROWS-1:0]   KeysState,
    output logic                             KeysValid
`ifdef PANEL_MS6205_EN
    ,
    input  logic [7:0]                       MsAddr,
    input  logic [7:0]                       MsData,
    input  logic                             MsReq,
    input  logic                             MsReady,
    output logic                             MsAck,
    output logic                             MsWriteAddr_n,
    output logic                             MsWriteData_n
`endif
);
    localparam int unsigned FW     = $clog2(FRAME_TICKS);
    localparam int unsigned KEYS_W = ANODE_COUNT * KB_ROWS;

    phase_e              state_q, state_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic [3:0]          anode_q, anode_d;
    logic [7:0]          bus_q, bus_d, bus_sel;
    logic [KEYS_W-1:0]   keys_q, keys_d, row_mask, row_bits;
    logic                valid_q, valid_d;
    logic                clr_q, clr_d, cath_q, cath_d, anode_stb_q, anode_stb_d;
    logic                kbwr_q, kbwr_d, kbrd_q, kbrd_d;
    logic [DIGIT_WIDTH-1:0] dig_hi, dig_lo;
    logic                frame_wrap_c, phase_end_c, strobe_win_c;
`ifdef PANEL_MS6205_EN
    logic                ms_ack_q, ms_ack_d, ms_wa_n_q, ms_wa_n_d, ms_wd_n_q, ms_wd_n_d;
`endif

    panel_phase_timer #(.PHASE_TICKS(PHASE_TICKS)) u_phase_timer (
        .clk          (Clk),
        .rst          (Rst),
        .tick         (Tick),
        .active       (state_q != PH_IDLE),
        .phase_end_c  (phase_end_c),
        .strobe_win_c (strobe_win_c)
    );

    assign frame_wrap_c = Tick && (frame_q == FW'(FRAME_TICKS - 1));

    // Frame timer, phase sequencing, key capture and anode advance
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        anode_d  = anode_q;
        keys_d   = keys_q;
        valid_d  = 1'b0;
        row_mask = KEYS_W'({KB_ROWS{1'b1}}) << (int'(anode_q) * KB_ROWS);
        row_bits = KEYS_W'(KbRow) << (int'(anode_q) * KB_ROWS);
`ifdef PANEL_MS6205_EN
        ms_ack_d = 1'b0;
`endif
        if (Tick) frame_d = frame_wrap_c ? '0 : frame_q + FW'(1);

        case (state_q)
            PH_IDLE:  if (frame_wrap_c) state_d = PH_CLEAR;
            PH_CLEAR: if (phase_end_c)  state_d = PH_CATH;
            PH_CATH:  if (phase_end_c)  state_d = PH_ANODE;
            PH_ANODE: if (phase_end_c)  state_d = PH_KBWR;
            PH_KBWR:  if (phase_end_c)  state_d = PH_KBRD;
            PH_KBRD: begin
                if (phase_end_c) begin
                    keys_d = (keys_q & ~row_mask) | row_bits;
`ifdef PANEL_MS6205_EN
                    state_d = (MsReq && MsReady) ? PH_MSADDR : PH_IDLE;
`else
                    state_d = PH_IDLE;
`endif
                end
            end
`ifdef PANEL_MS6205_EN
            PH_MSADDR: if (phase_end_c) state_d = PH_MSDATA;
            PH_MSDATA: begin
                if (phase_end_c) begin
                    state_d  = PH_IDLE;
                    ms_ack_d = 1'b1;
                end
            end
`endif
            default: state_d = PH_IDLE;
        endcase

        if ((state_q != PH_IDLE) && (state_d == PH_IDLE)) begin
            if (anode_q == 4'(ANODE_COUNT - 1)) begin
                anode_d = '0;
                valid_d = 1'b1;
            end else begin
                anode_d = anode_q + 4'd1;
            end
        end
    end

    // Bus payload is chosen once on phase entry and held for the whole phase
    always_comb begin
        dig_hi  = DIGIT_WIDTH'(DigitsHigh >> (int'(anode_q) * DIGIT_WIDTH));
        dig_lo  = DIGIT_WIDTH'(DigitsLow  >> (int'(anode_q) * DIGIT_WIDTH));
        bus_sel = 8'h00;
        case (state_d)
            PH_CATH:   bus_sel = {4'(dig_hi), 4'(dig_lo)};
            PH_ANODE:  bus_sel = 8'(anode_q);
            PH_KBWR:   bus_sel = (anode_q < 4'd8) ? (8'h01 << anode_q) : 8'h00;
            PH_KBRD:   bus_sel = KBRD_BUS;
`ifdef PANEL_MS6205_EN
            PH_MSADDR: bus_sel = MsAddr;
            PH_MSDATA: bus_sel = MsData;
`endif
            default:   bus_sel = 8'h00;
        endcase
        bus_d = (state_d != state_q) ? bus_sel : bus_q;

        clr_d       = strobe_win_c && (state_d == PH_CLEAR);
        cath_d      = strobe_win_c && (state_d == PH_CATH);
        anode_stb_d = strobe_win_c && (state_d == PH_ANODE);
        kbwr_d      = strobe_win_c && (state_d == PH_KBWR);
        kbrd_d      = strobe_win_c && (state_d == PH_KBRD);
`ifdef PANEL_MS6205_EN
        ms_wa_n_d   = !(strobe_win_c && (state_d == PH_MSADDR));
        ms_wd_n_d   = !(strobe_win_c && (state_d == PH_MSDATA));
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= PH_IDLE;
            frame_q     <= '0;
            anode_q     <= '0;
            bus_q       <= 8'h00;
            keys_q      <= '0;
            valid_q     <= 1'b0;
            clr_q       <= 1'b0;
            cath_q      <= 1'b0;
            anode_stb_q <= 1'b0;
            kbwr_q      <= 1'b0;
            kbrd_q      <= 1'b0;
`ifdef PANEL_MS6205_EN
            ms_ack_q    <= 1'b0;
            ms_wa_n_q   <= 1'b1;
            ms_wd_n_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            anode_q     <= anode_d;
            bus_q       <= bus_d;
            keys_q      <= keys_d;
            valid_q     <= valid_d;
            clr_q       <= clr_d;
            cath_q      <= cath_d;
            anode_stb_q <= anode_stb_d;
            kbwr_q      <= kbwr_d;
            kbrd_q      <= kbrd_d;
`ifdef PANEL_MS6205_EN
            ms_ack_q    <= ms_ack_d;
            ms_wa_n_q   <= ms_wa_n_d;
            ms_wd_n_q   <= ms_wd_n_d;
`endif
        end
    end

    assign BusData      = bus_q;
    assign BusPhase     = state_q;
    assign WriteCathode = cath_q;
    assign WriteAnode   = anode_stb_q;
    assign KbWrite      = kbwr_q;
    assign KbRead       = kbrd_q;
    assign DispClear    = clr_q;
    assign KbClear      = clr_q;
    assign AnodeIdx     = anode_q;
    assign KeysState    = keys_q;
    assign KeysValid    = valid_q;
`ifdef PANEL_MS6205_EN
    assign MsAck         = ms_ack_q;
    assign MsWriteAddr_n = ms_wa_n_q;
    assign MsWriteData_n = ms_wd_n_q;
`endif

endmodule
